stream_ctrl: RTL

Run-control sequencer for the raw colour-bar video path, clocked from clk24M. It waits for the pixel PLL to lock, lets it settle, then releases the pattern generator's active-low reset. It counts completed frames by watching fv from the pixel domain. It stops streaming on request or after a programmed frame count, and drops the generator into reset on PLL loss or a stalled frame stream.

---
 rtl/stream_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/stream_ctrl.sv
// Run-control sequencer for the colour-bar video path: PLL lock/settle, generator reset release, frame counting.
// Optional build macro STREAM_CTRL_AUTORETRY_EN adds automatic recovery from fv watchdog timeouts.
module stream_ctrl #(
  parameter int LOCK_WAIT   = 2400,
  parameter int FV_TIMEOUT  = 1000000,
  parameter int FRAME_LIMIT = 0,
  parameter int CNT_W       = 20
) (
  input  logic        clk24M,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pll_lock,
  input  logic        fv_in,
  output logic        gen_rstn,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic        err_lock,
  output logic        err_timeout,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_DRAIN     = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FV_TIMEOUT - 1);
  localparam logic [15:0]      LIMIT        = 16'(FRAME_LIMIT);

  state_t st, st_nx;
  logic lock_meta, lock_s, fv_meta, fv_s, fv_d;
  logic fv_fall, fv_edge, limit_hit;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [15:0] frame_nx, frame_inc;
  logic err_lock_nx, err_timeout_nx, done_nx;
`ifdef STREAM_CTRL_AUTORETRY_EN
  logic [1:0] retry_cnt, retry_nx;
`endif

  assign fv_fall   = fv_d & ~fv_s;
  assign fv_edge   = fv_d ^ fv_s;
  assign frame_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
  assign limit_hit = (LIMIT != 16'd0) && fv_fall && (frame_inc == LIMIT);
  assign busy      = (st != S_IDLE) && (st != S_ERROR);
  assign state     = st;

  // The shared counter times the lock settle in SETTLE, the fv watchdog in RUN/DRAIN
  // and, with auto-retry, the reset hold in ERROR.
  always_comb begin
    st_nx          = st;
    cnt_nx         = cnt;
    frame_nx       = frame_cnt;
    err_lock_nx    = err_lock;
    err_timeout_nx = err_timeout;
    done_nx        = 1'b0;
`ifdef STREAM_CTRL_AUTORETRY_EN
    retry_nx       = fv_fall ? 2'd0 : retry_cnt;
`endif
    if ((st == S_RUN || st == S_DRAIN) && fv_fall)
      frame_nx = frame_inc;
    case (st)
      S_IDLE: begin
        if (start && !stop) begin
          st_nx          = S_WAIT_LOCK;
          cnt_nx         = '0;
          frame_nx       = 16'd0;
          err_lock_nx    = 1'b0;
          err_timeout_nx = 1'b0;
`ifdef STREAM_CTRL_AUTORETRY_EN
          retry_nx       = 2'd0;
`endif
        end
      end
      S_WAIT_LOCK: begin
        if (stop) st_nx = S_IDLE;
        else if (lock_s) begin
          st_nx  = S_SETTLE;
          cnt_nx = '0;
        end
      end
      S_SETTLE: begin
        cnt_nx = cnt + 1'b1;
        if (!lock_s) begin
          st_nx       = S_ERROR;
          err_lock_nx = 1'b1;
          cnt_nx      = '0;
        end else if (stop) begin
          st_nx  = S_IDLE;
          cnt_nx = '0;
        end else if (cnt == SETTLE_LAST) begin
          st_nx  = S_RUN;
          cnt_nx = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        cnt_nx = fv_edge ? '0 : cnt + 1'b1;
        if (!lock_s) begin
          st_nx       = S_ERROR;
          err_lock_nx = 1'b1;
          cnt_nx      = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          st_nx          = S_ERROR;
          err_timeout_nx = 1'b1;
          cnt_nx         = '0;
        end else if (st == S_DRAIN) begin
          if (fv_fall) begin
            st_nx   = S_IDLE;
            done_nx = 1'b1;
            cnt_nx  = '0;
          end
        end else if (limit_hit || (stop && !fv_s)) begin
          st_nx   = S_IDLE;
          done_nx = 1'b1;
          cnt_nx  = '0;
        end else if (stop) begin
          st_nx = S_DRAIN;
        end
      end
      S_ERROR: begin
        if (start) begin
          st_nx          = S_WAIT_LOCK;
          cnt_nx         = '0;
          err_lock_nx    = 1'b0;
          err_timeout_nx = 1'b0;
`ifdef STREAM_CTRL_AUTORETRY_EN
          retry_nx       = 2'd0;
        end else if (err_timeout && !err_lock && retry_cnt != 2'd3) begin
          cnt_nx = cnt + 1'b1;
          if (cnt == SETTLE_LAST) begin
            st_nx    = S_SETTLE;
            cnt_nx   = '0;
            retry_nx = retry_cnt + 2'd1;
          end
`endif
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk24M) begin
    if (!reset_n) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      fv_meta     <= 1'b0;
      fv_s        <= 1'b0;
      fv_d        <= 1'b0;
      st          <= S_IDLE;
      cnt         <= '0;
      frame_cnt   <= 16'd0;
      err_lock    <= 1'b0;
      err_timeout <= 1'b0;
      done        <= 1'b0;
      gen_rstn    <= 1'b0;
    end else begin
      lock_meta   <= pll_lock;
      lock_s      <= lock_meta;
      fv_meta     <= fv_in;
      fv_s        <= fv_meta;
      fv_d        <= fv_s;
      st          <= st_nx;
      cnt         <= cnt_nx;
      frame_cnt   <= frame_nx;
      err_lock    <= err_lock_nx;
      err_timeout <= err_timeout_nx;
      done        <= done_nx;
      gen_rstn    <= (st_nx == S_RUN) || (st_nx == S_DRAIN);
    end
  end

`ifdef STREAM_CTRL_AUTORETRY_EN
  always_ff @(posedge clk24M) begin
    if (!reset_n) retry_cnt <= 2'd0;
    else          retry_cnt <= retry_nx;
  end
`endif

endmodule
